// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_PASSB = 3'b100,
    OP_INC   = 3'b101,
    OP_SHL   = 3'b110,
    OP_MUL   = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Control-unit <-> ALU bundle: request, operands and registered results/flags.
interface alu_seq_if #(
  parameter int unsigned reg_width = 12
);
  logic                 start;
  logic [2:0]           op;
  logic [reg_width-1:0] a_in;
  logic [reg_width-1:0] b_in;
  logic [reg_width-1:0] result;
  logic                 done;
  logic                 busy;
  logic                 zero;
  logic                 carry;

  modport master (
    output start, op, a_in, b_in,
    input  result, done, busy, zero, carry
  );

  modport slave (
    input  start, op, a_in, b_in,
    output result, done, busy, zero, carry
  );
endinterface

// File: rtl/alu_seq_mult.sv
// Shift-add multiplier datapath: one multiplier bit per step, reg_width steps.
module seq_mult #(
  parameter int unsigned reg_width = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     step,
  input  logic [reg_width-1:0]     a,
  input  logic [reg_width-1:0]     b,
  output logic                     last,
  output logic [2*reg_width-1:0]   prod_next
);
  localparam int unsigned W  = reg_width;
  localparam int unsigned CW = $clog2(reg_width + 1);

  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] prod;
  logic [CW-1:0]  cnt;
  logic [W:0]     psum;

  // Add into the upper half, then shift the whole product right; the add's
  // carry becomes the new top bit.
  always_comb begin
    psum      = {1'b0, prod[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
    prod_next = {psum, prod[W-1:1]};
  end

  assign last = (cnt == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      prod   <= '0;
      cnt    <= CW'(W);
    end else if (step) begin
      prod   <= prod_next;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU feeding the accumulator: single-cycle ops plus a multi-cycle
// shift-add multiply; registered result/flags with a one-cycle done pulse.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned reg_width = 12
) (
  input  logic        clk,
  input  logic        reset,
  alu_seq_if.slave    bus
);
  localparam int unsigned W = reg_width;

  state_e         state_q, state_d;
  logic           mul_load, mul_step, mul_last;
  logic [2*W-1:0] mul_prod_next;
  logic           upd;
  logic [W-1:0]   res_d;
  logic           carry_d;
  logic [W:0]     sum;

  seq_mult #(.reg_width(W)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .load      (mul_load),
    .step      (mul_step),
    .a         (bus.a_in),
    .b         (bus.b_in),
    .last      (mul_last),
    .prod_next (mul_prod_next)
  );

  // Every single-cycle op is formed as a (W+1)-bit value whose top bit is the flag.
  always_comb begin
    state_d  = state_q;
    mul_load = 1'b0;
    mul_step = 1'b0;
    upd      = 1'b0;
    sum      = '0;
    res_d    = '0;
    carry_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (op_e'(bus.op) == OP_MUL) begin
            mul_load = 1'b1;
            state_d  = MULT;
          end else begin
            upd = 1'b1;
            case (op_e'(bus.op))
              OP_ADD:   sum = {1'b0, bus.a_in} + {1'b0, bus.b_in};
              OP_SUB:   sum = {1'b0, bus.a_in} - {1'b0, bus.b_in};
              OP_AND:   sum = {1'b0, bus.a_in & bus.b_in};
              OP_OR:    sum = {1'b0, bus.a_in | bus.b_in};
              OP_PASSB: sum = {1'b0, bus.b_in};
              OP_INC:   sum = {1'b0, bus.a_in} + (W+1)'(1);
              OP_SHL:   sum = {bus.a_in, 1'b0};
              default:  sum = '0;
            endcase
            res_d   = sum[W-1:0];
            carry_d = sum[W];
          end
        end
      end
      MULT: begin
        mul_step = 1'b1;
        if (mul_last) begin
          upd     = 1'b1;
          res_d   = mul_prod_next[W-1:0];
          carry_d = |mul_prod_next[2*W-1:W];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bus.result <= '0;
      bus.zero   <= 1'b1;
      bus.carry  <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.done <= upd;
      if (upd) begin
        bus.result <= res_d;
        bus.zero   <= (res_d == '0);
        bus.carry  <= carry_d;
      end
    end
  end

  assign bus.busy = (state_q == MULT);
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 12;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_seq_if #(.reg_width(W)) bus_if ();

  alu_seq #(.reg_width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {carry, result} computed with plain unsigned arithmetic.
  function automatic logic [W:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned m, av, bv, r;
    logic c;
    m  = 64'(1) << W;
    av = 64'(a);
    bv = 64'(b);
    c  = 1'b0;
    case (op)
      3'd0: begin r = av + bv; c = (r >= m); end
      3'd1: begin r = (av + m - bv) % m; c = (av < bv); end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = bv;
      3'd5: begin r = av + 1; c = (r >= m); end
      3'd6: begin r = av * 2; c = (r >= m); end
      default: begin r = av * bv; c = ((r / m) != 0); end
    endcase
    return {c, W'(r % m)};
  endfunction

  task automatic check_outputs(input string tag, input logic [W:0] e);
    check({tag, "_done"},   32'(bus_if.done),   32'(1));
    check({tag, "_busy"},   32'(bus_if.busy),   32'(0));
    check({tag, "_result"}, 32'(bus_if.result), 32'(e[W-1:0]));
    check({tag, "_carry"},  32'(bus_if.carry),  32'(e[W]));
    check({tag, "_zero"},   32'(bus_if.zero),   32'(e[W-1:0] == '0));
  endtask

  // Waits for done after an accepted MUL; n = edges since the accepting edge.
  task automatic wait_mul(input string tag);
    int n;
    n = 0;
    while (!bus_if.done && n < 40) begin
      bus_if.a_in = W'($urandom);
      bus_if.b_in = W'($urandom);
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(W));
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] e;
    e = model(op, a, b);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.a_in  = a;
    bus_if.b_in  = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.a_in  = W'($urandom);
    bus_if.b_in  = W'($urandom);
    if (op == 3'd7) begin
      check({tag, "_busy_on"}, 32'(bus_if.busy), 32'(1));
      check({tag, "_early"},   32'(bus_if.done), 32'(0));
      wait_mul(tag);
    end
    check_outputs(tag, e);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus_if.done), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int dones;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;

    reset        = 1'b0;
    bus_if.start = 1'b0;
    bus_if.op    = '0;
    bus_if.a_in  = '0;
    bus_if.b_in  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_result", 32'(bus_if.result), 32'(0));
    check("rst_zero",   32'(bus_if.zero),   32'(1));
    check("rst_carry",  32'(bus_if.carry),  32'(0));
    check("rst_done",   32'(bus_if.done),   32'(0));
    check("rst_busy",   32'(bus_if.busy),   32'(0));

    run_op("add_wrap", 3'd0, 12'hFFF, 12'h001);
    run_op("sub_borrow", 3'd1, 12'h005, 12'h007);
    run_op("shl_msb", 3'd6, 12'h800, 12'h000);
    run_op("mul_small", 3'd7, 12'h012, 12'h010);
    run_op("mul_ovf", 3'd7, 12'h100, 12'h100);
    run_op("inc_wrap", 3'd5, 12'hFFF, 12'h000);
    run_op("passb", 3'd4, 12'h0AA, 12'h555);
    run_op("mul_max", 3'd7, 12'hFFF, 12'hFFF);

    // Start during busy is dropped; start in the done cycle is accepted.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = 3'd7;
    bus_if.a_in  = 12'h0AB;
    bus_if.b_in  = 12'h0CD;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = 3'd0;
    bus_if.a_in  = 12'h001;
    bus_if.b_in  = 12'h002;
    @(negedge clk);
    bus_if.start = 1'b0;
    dones = 4;
    while (!bus_if.done && dones < 40) begin
      @(negedge clk);
      dones++;
    end
    check("busy_ign_latency", 32'(dones), 32'(W));
    check_outputs("busy_ign_mul", model(3'd7, 12'h0AB, 12'h0CD));
    bus_if.start = 1'b1;
    bus_if.op    = 3'd0;
    bus_if.a_in  = 12'h123;
    bus_if.b_in  = 12'h456;
    @(negedge clk);
    bus_if.start = 1'b0;
    check_outputs("b2b_add", model(3'd0, 12'h123, 12'h456));
    @(negedge clk);
    check("b2b_pulse", 32'(bus_if.done), 32'(0));

    // Reset asserted mid-multiply.
    bus_if.start = 1'b1;
    bus_if.op    = 3'd7;
    bus_if.a_in  = 12'h0F0;
    bus_if.b_in  = 12'h0F0;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_result", 32'(bus_if.result), 32'(0));
    check("mrst_zero",   32'(bus_if.zero),   32'(1));
    check("mrst_carry",  32'(bus_if.carry),  32'(0));
    check("mrst_done",   32'(bus_if.done),   32'(0));
    check("mrst_busy",   32'(bus_if.busy),   32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus_if.done) dones++;
    end
    check("mrst_no_done", 32'(dones), 32'(0));
    run_op("mul_after_rst", 3'd7, 12'h003, 12'h004);

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (i % 10 == 0) ra = '1;
      if (i % 10 == 5) rb = '0;
      run_op("rand", rop, ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential arithmetic/logic unit that sits directly upstream of the accumulator. It combines the accumulator's current value with an operand taken from the bus and produces the value the accumulator loads. Single-cycle operations complete in one clock; multiply runs as a shift-add over `reg_width` cycles. A one-cycle `done` pulse drives the accumulator's write enable.

## Interface
- `reg_width`, default 12: datapath width of the operands, the result and the multiply iteration count.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserted low, released high.
- `start`  in  1  from control unit; requests an operation, accepted only while `busy`=0.
- `op`  in  3  operation select, sampled with `start`.
- `a_in`  in  reg_width  operand A, the accumulator's current value.
- `b_in`  in  reg_width  operand B, from the bus.
- `result`  out  reg_width  registered result; feeds the accumulator data input.
- `done`  out  1  one-cycle pulse when `result`/flags update; drives the accumulator write enable.
- `busy`  out  1  high while a multiply is in progress.
- `zero`  out  1  registered; `result`==0.
- `carry`  out  1  registered carry/borrow/overflow, defined per op below.

## Operation
- Op encodings:
  - 000 ADD: C = carry out.
  - 001 SUB (A−B): C = borrow, i.e. A<B unsigned.
  - 010 AND: C=0.
  - 011 OR: C=0.
  - 100 PASSB (result = B): C=0.
  - 101 INC (A+1): C = carry out.
  - 110 SHL (A<<1): C = A[msb].
  - 111 MUL (unsigned A×B, low `reg_width` bits): C=1 if the upper `reg_width` product bits are nonzero.
- Arithmetic is unsigned, modulo 2^reg_width. Internal sums are reg_width+1 bits wide, and the multiply accumulator is 2·reg_width bits.
- Operands are captured when a start is accepted. Later changes on `a_in`/`b_in` do not affect an operation in flight.
- States:
  - IDLE: on `start`=1 with a non-MUL op, write result, flags and `done`=1, then stay in IDLE. On `start`=1 with MUL, capture operands, clear the product, load counter = reg_width, go to MULT.
  - MULT: each cycle, if multiplier[0]=1 add the multiplicand into the upper product half; shift right; decrement the counter. When the counter reaches 1, on that edge write result and flags, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored. It is not queued, and no `done` is produced for it.
- `result`, `zero` and `carry` hold their values until the next `done`.
- Reset values: `result`=0, `done`=0, `busy`=0, `zero`=1, `carry`=0; state=IDLE; counter and product registers=0.
- Reset asserted mid-multiply aborts immediately. No `done` is produced, and the next start after release behaves normally.

## Timing
- Non-MUL ops: `start` sampled at edge E0 → `result`, flags and `done`=1 valid after E0, with `done` low again after E1. Latency 1. `busy` stays 0.
- MUL: `start` at E0 → `busy`=1 after E0. Iterations occur on E1…E(reg_width). After E(reg_width), `done`=1, `busy`=0 and result is valid. Latency reg_width edges after accept (12 for the default).
- `busy` falls in the same cycle `done` rises. A `start` in that cycle is accepted, so back-to-back operations have zero bubble.
- `done` never stays high for two consecutive cycles unless a new start is accepted in the done cycle.

## Structure
- Shared package `alu_pkg`: op encoding constants (ADD … MUL) and the state enum (IDLE, MULT).
- One sub-module is natural: `seq_mult`, containing the shift-add multiplier datapath (multiplicand, multiplier shift register, 2·reg_width product, counter) with a start/last handshake. The top level holds the FSM, single-cycle ops and output registers.

## Test plan
- Reset values: hold `reset` low, then release → `result`=0x000, `zero`=1, `carry`=0, `done`=0, `busy`=0.
- ADD wrap: A=0xFFF, B=0x001, start → one cycle later `result`=0x000, `zero`=1, `carry`=1, `done` high exactly one cycle.
- SUB borrow and SHL: A=0x005, B=0x007 → `result`=0xFFE, `carry`=1. Then SHL with A=0x800 → `result`=0x000, `carry`=1, `zero`=1.
- MUL:
  - A=0x012, B=0x010 → `busy` for 12 cycles, `done` at edge 12, `result`=0x120, `carry`=0.
  - A=0x100, B=0x100 → `result`=0x000, `zero`=1, `carry`=1.
- Start during busy: pulse ADD start at iteration 4 of a MUL → ignored. Only the MUL's `done` appears, with the correct product. An ADD start in the done cycle is accepted, and its `done` follows one cycle later.
- Reset mid-MUL: drive `reset` low at iteration 5 → all outputs take reset values asynchronously, with no `done`. After release, MUL 0x003×0x004 → `result`=0x00C.
